// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution and a back-pressured EX/MEM register.
// Optional multi-cycle MUL/MULH/MULHSU/MULHU unit, enabled by defining EX_STAGE_MUL_EN.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ex_valid,
  input  logic [31:0] id_ex_pc,
  input  logic [31:0] id_ex_pc_4,
  input  logic [31:0] id_ex_rs1_data,
  input  logic [31:0] id_ex_rs2_data,
  input  logic [4:0]  id_ex_rd,
  input  logic [2:0]  id_ex_funct3,
  input  logic [6:0]  id_ex_funct7,
  input  logic [6:0]  id_ex_opcode,
  input  logic [31:0] id_ex_imm,
  output logic        ex_ready,
  input  logic        ex_mem_ready,
  output logic        ex_mem_valid,
  output logic        ex_mem_reg_write,
  output logic        ex_mem_illegal,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_rs2_data,
  output logic [31:0] ex_mem_pc_4,
  output logic [4:0]  ex_mem_rd,
  output logic [2:0]  ex_mem_funct3,
  output logic [6:0]  ex_mem_opcode,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

`ifdef EX_STAGE_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [1:0] {StIdle, StMul1, StMul2} state_e;

  state_e      r_state, w_state_next;
  logic        r_valid, r_reg_write, r_illegal, r_redirect_valid;
  logic [31:0] r_alu_result, r_rs2_data, r_pc_4, r_redirect_pc;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [6:0]  r_opcode;
  logic [31:0] r_mul_a, r_mul_b, r_mul_pc_4;
  logic [4:0]  r_mul_rd;
  logic [2:0]  r_mul_funct3;
  logic [63:0] r_mul_prod;

  logic        w_is_op, w_is_opimm, w_is_jal, w_is_jalr, w_is_branch, w_is_rv32i;
  logic        w_op_f7_ok, w_is_mul, w_legal, w_reg_write, w_taken, w_redirect;
  logic        w_transfer, w_slot_free, w_sub, w_lt, w_ltu;
  logic [31:0] w_op2, w_alu, w_result, w_target, w_mul_result;
  logic [4:0]  w_shamt;
  logic        w_mul_sa, w_mul_sb;
  logic [63:0] w_mul_prod;

  // Decode
  assign w_is_op     = (id_ex_opcode == OpReg);
  assign w_is_opimm  = (id_ex_opcode == OpImm);
  assign w_is_jal    = (id_ex_opcode == OpJal);
  assign w_is_jalr   = (id_ex_opcode == OpJalr);
  assign w_is_branch = (id_ex_opcode == OpBranch);
  assign w_is_rv32i  = w_is_opimm | w_is_jal | w_is_jalr | w_is_branch |
                       (id_ex_opcode == OpLui) | (id_ex_opcode == OpAuipc) |
                       (id_ex_opcode == OpLoad) | (id_ex_opcode == OpStore) |
                       (id_ex_opcode == OpFence) | (id_ex_opcode == OpSystem);
  // funct7=0100000 is only meaningful for SUB and SRA
  assign w_op_f7_ok  = (id_ex_funct7 == 7'b0000000) ||
                       ((id_ex_funct7 == 7'b0100000) &&
                        ((id_ex_funct3 == 3'b000) || (id_ex_funct3 == 3'b101)));
  assign w_is_mul    = MulEn && w_is_op && (id_ex_funct7 == 7'b0000001) && !id_ex_funct3[2];
  assign w_legal     = w_is_rv32i || (w_is_op && (w_op_f7_ok || w_is_mul));
  assign w_reg_write = w_legal && (id_ex_rd != 5'd0) &&
                       (w_is_op || w_is_opimm || w_is_jal || w_is_jalr ||
                        (id_ex_opcode == OpLui) || (id_ex_opcode == OpAuipc) ||
                        (id_ex_opcode == OpLoad));

  // ALU
  assign w_op2   = w_is_op ? id_ex_rs2_data : id_ex_imm;
  assign w_shamt = w_op2[4:0];
  assign w_sub   = w_is_op && id_ex_funct7[5];

  always_comb begin
    w_alu = '0;
    case (id_ex_funct3)
      3'b000: w_alu = w_sub ? id_ex_rs1_data - w_op2 : id_ex_rs1_data + w_op2;
      3'b001: w_alu = id_ex_rs1_data << w_shamt;
      3'b010: w_alu = {31'd0, $signed(id_ex_rs1_data) < $signed(w_op2)};
      3'b011: w_alu = {31'd0, id_ex_rs1_data < w_op2};
      3'b100: w_alu = id_ex_rs1_data ^ w_op2;
      3'b101: w_alu = id_ex_funct7[5] ? 32'($signed(id_ex_rs1_data) >>> w_shamt)
                                      : id_ex_rs1_data >> w_shamt;
      3'b110: w_alu = id_ex_rs1_data | w_op2;
      3'b111: w_alu = id_ex_rs1_data & w_op2;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_result = '0;
    if (w_legal) begin
      case (id_ex_opcode)
        OpReg, OpImm:    w_result = w_alu;
        OpLui:           w_result = id_ex_imm;
        OpAuipc:         w_result = id_ex_pc + id_ex_imm;
        OpJal, OpJalr:   w_result = id_ex_pc_4;
        OpLoad, OpStore: w_result = id_ex_rs1_data + id_ex_imm;
        default:         w_result = '0;
      endcase
    end
  end

  // Branch / jump resolution
  assign w_lt  = $signed(id_ex_rs1_data) < $signed(id_ex_rs2_data);
  assign w_ltu = id_ex_rs1_data < id_ex_rs2_data;

  always_comb begin
    w_taken = 1'b0;
    case (id_ex_funct3)
      3'b000:  w_taken = (id_ex_rs1_data == id_ex_rs2_data);
      3'b001:  w_taken = (id_ex_rs1_data != id_ex_rs2_data);
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = !w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_redirect = w_is_jal || w_is_jalr || (w_is_branch && w_taken);
  assign w_target   = w_is_jalr ? ((id_ex_rs1_data + id_ex_imm) & ~32'd1)
                                : id_ex_pc + id_ex_imm;

  // Multiplier: 64-bit product of sign/zero-extended operands gives all four variants
  assign w_mul_sa     = (r_mul_funct3 != 3'b011);
  assign w_mul_sb     = (r_mul_funct3 == 3'b001);
  assign w_mul_prod   = {{32{w_mul_sa & r_mul_a[31]}}, r_mul_a} *
                        {{32{w_mul_sb & r_mul_b[31]}}, r_mul_b};
  assign w_mul_result = (r_mul_funct3 == 3'b000) ? r_mul_prod[31:0] : r_mul_prod[63:32];

  // Handshake
  assign w_slot_free = !r_valid || ex_mem_ready;
  assign ex_ready    = (r_state == StIdle) && w_slot_free;
  assign w_transfer  = id_ex_valid && ex_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_transfer && w_is_mul) w_state_next = StMul1;
      StMul1:  w_state_next = StMul2;
      StMul2:  if (w_slot_free) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid          <= 1'b0;
      r_reg_write      <= 1'b0;
      r_illegal        <= 1'b0;
      r_alu_result     <= '0;
      r_rs2_data       <= '0;
      r_pc_4           <= '0;
      r_rd             <= '0;
      r_funct3         <= '0;
      r_opcode         <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_mul_a          <= '0;
      r_mul_b          <= '0;
      r_mul_pc_4       <= '0;
      r_mul_rd         <= '0;
      r_mul_funct3     <= '0;
      r_mul_prod       <= '0;
    end else begin
      r_redirect_valid <= w_transfer && w_redirect;
      if (w_transfer && w_redirect) r_redirect_pc <= w_target;

      if (w_transfer && !w_is_mul) begin
        r_valid      <= 1'b1;
        r_reg_write  <= w_reg_write;
        r_illegal    <= !w_legal;
        r_alu_result <= w_result;
        r_rs2_data   <= id_ex_rs2_data;
        r_pc_4       <= id_ex_pc_4;
        r_rd         <= id_ex_rd;
        r_funct3     <= id_ex_funct3;
        r_opcode     <= id_ex_opcode;
      end else if ((r_state == StMul2) && w_slot_free) begin
        r_valid      <= 1'b1;
        r_reg_write  <= (r_mul_rd != 5'd0);
        r_illegal    <= 1'b0;
        r_alu_result <= w_mul_result;
        r_rs2_data   <= r_mul_b;
        r_pc_4       <= r_mul_pc_4;
        r_rd         <= r_mul_rd;
        r_funct3     <= r_mul_funct3;
        r_opcode     <= OpReg;
      end else if (ex_mem_ready) begin
        r_valid <= 1'b0;
      end

      if (w_transfer && w_is_mul) begin
        r_mul_a      <= id_ex_rs1_data;
        r_mul_b      <= id_ex_rs2_data;
        r_mul_pc_4   <= id_ex_pc_4;
        r_mul_rd     <= id_ex_rd;
        r_mul_funct3 <= id_ex_funct3;
      end
      if (r_state == StMul1) r_mul_prod <= w_mul_prod;
    end
  end

  assign ex_mem_valid      = r_valid;
  assign ex_mem_reg_write  = r_reg_write;
  assign ex_mem_illegal    = r_illegal;
  assign ex_mem_alu_result = r_alu_result;
  assign ex_mem_rs2_data   = r_rs2_data;
  assign ex_mem_pc_4       = r_pc_4;
  assign ex_mem_rd         = r_rd;
  assign ex_mem_funct3     = r_funct3;
  assign ex_mem_opcode     = r_opcode;
  assign redirect_valid    = r_redirect_valid;
  assign redirect_pc       = r_redirect_pc;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, stall/reset sequences, randomized model check.
// Multiply sequences are built only when EX_STAGE_MUL_EN is defined.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_ex_valid = 1'b0;
  logic [31:0] id_ex_pc = '0, id_ex_pc_4 = '0, id_ex_rs1_data = '0, id_ex_rs2_data = '0;
  logic [4:0]  id_ex_rd = '0;
  logic [2:0]  id_ex_funct3 = '0;
  logic [6:0]  id_ex_funct7 = '0, id_ex_opcode = '0;
  logic [31:0] id_ex_imm = '0;
  logic        ex_ready;
  logic        ex_mem_ready = 1'b1;
  logic        ex_mem_valid, ex_mem_reg_write, ex_mem_illegal;
  logic [31:0] ex_mem_alu_result, ex_mem_rs2_data, ex_mem_pc_4;
  logic [4:0]  ex_mem_rd;
  logic [2:0]  ex_mem_funct3;
  logic [6:0]  ex_mem_opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_pc_4(id_ex_pc_4), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_rd(id_ex_rd), .id_ex_funct3(id_ex_funct3), .id_ex_funct7(id_ex_funct7),
    .id_ex_opcode(id_ex_opcode), .id_ex_imm(id_ex_imm), .ex_ready(ex_ready),
    .ex_mem_ready(ex_mem_ready), .ex_mem_valid(ex_mem_valid),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_illegal(ex_mem_illegal),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_rs2_data(ex_mem_rs2_data),
    .ex_mem_pc_4(ex_mem_pc_4), .ex_mem_rd(ex_mem_rd), .ex_mem_funct3(ex_mem_funct3),
    .ex_mem_opcode(ex_mem_opcode), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        rw;
    logic        ill;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1, rs2, imm, pc;
    logic [4:0]  rd;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rd);
    id_ex_valid    = 1'b1;
    id_ex_opcode   = op;
    id_ex_funct3   = f3;
    id_ex_funct7   = f7;
    id_ex_rs1_data = rs1;
    id_ex_rs2_data = rs2;
    id_ex_imm      = imm;
    id_ex_pc       = pc;
    id_ex_pc_4     = pc + 32'd4;
    id_ex_rd       = rd;
  endtask

  task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res,
                         input logic rw, input logic ill, input logic rv, input logic [31:0] rpc);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.rd = rd; v.e.res = res; v.e.rw = rw; v.e.ill = ill; v.e.rv = rv; v.e.rpc = rpc;
    vecs.push_back(v);
  endtask

  // Reference model: instruction semantics written from the ISA rules
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b & 32'd31;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

`ifdef EX_STAGE_MUL_EN
  function automatic logic [31:0] mul_ref(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0, 3'd1: p = sa * sb;
      3'd2:       p = sa * ub;
      default:    p = ua * ub;
    endcase
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction
`endif

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [4:0] rd);
    exp_t e;
    logic writes;
    e = '0;
    writes = 1'b0;
    case (op)
      7'h33: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          e.res = alu_ref(f3, f7[5], rs1, rs2);
          writes = 1'b1;
`ifdef EX_STAGE_MUL_EN
        end else if (f7 == 7'h01 && f3 < 3'd4) begin
          e.res = mul_ref(f3, rs1, rs2);
          writes = 1'b1;
`endif
        end else begin
          e.ill = 1'b1;
        end
      end
      7'h13: begin e.res = alu_ref(f3, (f3 == 3'd5) && f7[5], rs1, imm); writes = 1'b1; end
      7'h37: begin e.res = imm; writes = 1'b1; end
      7'h17: begin e.res = pc + imm; writes = 1'b1; end
      7'h6f: begin e.res = pc + 32'd4; writes = 1'b1; e.rv = 1'b1; e.rpc = pc + imm; end
      7'h67: begin
        e.res = pc + 32'd4; writes = 1'b1; e.rv = 1'b1; e.rpc = (rs1 + imm) & 32'hFFFF_FFFE;
      end
      7'h03: begin e.res = rs1 + imm; writes = 1'b1; end
      7'h23: e.res = rs1 + imm;
      7'h63: begin
        case (f3)
          3'd0: e.rv = (rs1 == rs2);
          3'd1: e.rv = (rs1 != rs2);
          3'd4: e.rv = ($signed(rs1) < $signed(rs2));
          3'd5: e.rv = ($signed(rs1) >= $signed(rs2));
          3'd6: e.rv = (rs1 < rs2);
          3'd7: e.rv = (rs1 >= rs2);
          default: e.rv = 1'b0;
        endcase
        e.rpc = pc + imm;
      end
      7'h0f, 7'h73: e.res = '0;
      default: e.ill = 1'b1;
    endcase
    e.rw = writes && (rd != 5'd0);
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m_valid, m_rv, xfer;
    exp_t        e;
    logic [31:0] m_res, m_rs2, m_pc4, m_rpc, tmp;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_op;
    logic        m_rw, m_ill;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, imm, pc;
    logic [4:0]  rd;

    // Asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk1("reset_valid", ex_mem_valid, 1'b0);
    chk("reset_result", ex_mem_alu_result, 32'd0);
    chk1("reset_redirect", redirect_valid, 1'b0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk1("reset_ex_ready", ex_ready, 1'b1);
    step;
    step;
    rst = 1'b0;

    add_vec(7'h13, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'h0, 5'd5,
            32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h63, 3'd0, 7'h00, 32'd3, 32'd3, 32'h20, 32'h100, 5'd0,
            32'd0, 1'b0, 1'b0, 1'b1, 32'h120);
    add_vec(7'h63, 3'd1, 7'h00, 32'd3, 32'd3, 32'h20, 32'h100, 5'd0,
            32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec(7'h67, 3'd0, 7'h00, 32'h1001, 32'd0, 32'd0, 32'h40, 5'd1,
            32'h44, 1'b1, 1'b0, 1'b1, 32'h1000);
    add_vec(7'h33, 3'd0, 7'h20, 32'd5, 32'd7, 32'd0, 32'h0, 5'd3,
            32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'h24, 32'd0, 32'h0, 5'd3,
            32'hF800_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h33, 3'd5, 7'h00, 32'h8000_0000, 32'h4, 32'd0, 32'h0, 5'd3,
            32'h0800_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h33, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 5'd3,
            32'd1, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h33, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 5'd3,
            32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h37, 3'd0, 7'h00, 32'd0, 32'd0, 32'h1234_5000, 32'h0, 5'd0,
            32'h1234_5000, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec(7'h17, 3'd0, 7'h00, 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd2,
            32'h3000, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h6f, 3'd0, 7'h00, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h200, 5'd1,
            32'h204, 1'b1, 1'b0, 1'b1, 32'h1F0);
    add_vec(7'h23, 3'd2, 7'h00, 32'h100, 32'hABCD, 32'hFFFF_FFFC, 32'h0, 5'd0,
            32'hFC, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec(7'h03, 3'd2, 7'h00, 32'h10, 32'd0, 32'd8, 32'h0, 5'd4,
            32'h18, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h7F, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 32'h0, 5'd3,
            32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    add_vec(7'h63, 3'd6, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'd8, 32'h80, 5'd0,
            32'd0, 1'b0, 1'b0, 1'b1, 32'h88);
    add_vec(7'h63, 3'd5, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h80, 5'd0,
            32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec(7'h13, 3'd4, 7'h00, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_FFFF, 32'h0, 5'd6,
            32'h0F0F_0F0F, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h33, 3'd1, 7'h00, 32'd1, 32'h3F, 32'd0, 32'h0, 5'd6,
            32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(7'h33, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h0, 5'd6,
            32'd1, 1'b1, 1'b0, 1'b0, 32'd0);
`ifndef EX_STAGE_MUL_EN
    add_vec(7'h33, 3'd0, 7'h01, 32'd3, 32'd4, 32'd0, 32'h0, 5'd6,
            32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
`endif

    ex_mem_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
            vecs[i].pc, vecs[i].rd);
      step;
      chk1($sformatf("v%0d_valid", i), ex_mem_valid, 1'b1);
      chk($sformatf("v%0d_result", i), ex_mem_alu_result, vecs[i].e.res);
      chk1($sformatf("v%0d_reg_write", i), ex_mem_reg_write, vecs[i].e.rw);
      chk1($sformatf("v%0d_illegal", i), ex_mem_illegal, vecs[i].e.ill);
      chk1($sformatf("v%0d_redirect", i), redirect_valid, vecs[i].e.rv);
      if (vecs[i].e.rv) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e.rpc);
      chk($sformatf("v%0d_rd", i), 32'(ex_mem_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rs2", i), ex_mem_rs2_data, vecs[i].rs2);
      chk($sformatf("v%0d_pc_4", i), ex_mem_pc_4, vecs[i].pc + 32'd4);
      chk($sformatf("v%0d_funct3", i), 32'(ex_mem_funct3), 32'(vecs[i].f3));
      chk($sformatf("v%0d_opcode", i), 32'(ex_mem_opcode), 32'(vecs[i].op));
    end
    id_ex_valid = 1'b0;
    step;
    chk1("idle_redirect_clear", redirect_valid, 1'b0);
    chk1("idle_valid_clear", ex_mem_valid, 1'b0);

    // Back-pressure: result held for three cycles, next instruction waits
    drive(7'h33, 3'd0, 7'h00, 32'd10, 32'd20, 32'd0, 32'h0, 5'd7);
    step;
    chk("stall_first_result", ex_mem_alu_result, 32'd30);
    drive(7'h13, 3'd0, 7'h00, 32'd1, 32'd0, 32'd1, 32'h0, 5'd8);
    ex_mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1($sformatf("stall%0d_ex_ready", c), ex_ready, 1'b0);
      step;
      chk1($sformatf("stall%0d_valid", c), ex_mem_valid, 1'b1);
      chk($sformatf("stall%0d_result", c), ex_mem_alu_result, 32'd30);
      chk($sformatf("stall%0d_rd", c), 32'(ex_mem_rd), 32'd7);
    end
    ex_mem_ready = 1'b1;
    #1;
    chk1("release_ex_ready", ex_ready, 1'b1);
    step;
    chk("release_result", ex_mem_alu_result, 32'd2);
    chk("release_rd", 32'(ex_mem_rd), 32'd8);
    id_ex_valid = 1'b0;
    step;
    chk1("release_drain", ex_mem_valid, 1'b0);

    // Mid-cycle reset clears a pending result and redirect
    drive(7'h6f, 3'd0, 7'h00, 32'd0, 32'd0, 32'h40, 32'h300, 5'd1);
    step;
    id_ex_valid = 1'b0;
    ex_mem_ready = 1'b0;
    chk1("pre_rst_redirect", redirect_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_valid", ex_mem_valid, 1'b0);
    chk("async_rst_result", ex_mem_alu_result, 32'd0);
    chk1("async_rst_redirect", redirect_valid, 1'b0);
    chk("async_rst_redirect_pc", redirect_pc, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ex_mem_ready = 1'b1;

`ifdef EX_STAGE_MUL_EN
    drive(7'h33, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0, 5'd9);
    #1;
    chk1("mulhu_accept", ex_ready, 1'b1);
    step;
    drive(7'h13, 3'd0, 7'h00, 32'd5, 32'd0, 32'd6, 32'h0, 5'd10);
    chk1("mulhu_e1_ready", ex_ready, 1'b0);
    chk1("mulhu_e1_valid", ex_mem_valid, 1'b0);
    step;
    chk1("mulhu_e2_ready", ex_ready, 1'b0);
    chk1("mulhu_e2_valid", ex_mem_valid, 1'b0);
    step;
    chk1("mulhu_e3_valid", ex_mem_valid, 1'b1);
    chk("mulhu_e3_result", ex_mem_alu_result, 32'hFFFF_FFFE);
    chk1("mulhu_e3_reg_write", ex_mem_reg_write, 1'b1);
    chk("mulhu_e3_rd", 32'(ex_mem_rd), 32'd9);
    chk1("mulhu_e3_ready", ex_ready, 1'b1);
    step;
    chk("mul_next_result", ex_mem_alu_result, 32'd11);
    chk("mul_next_rd", 32'(ex_mem_rd), 32'd10);
    for (int k = 0; k < 8; k++) begin
      f3  = 3'(k & 3);
      rs1 = $urandom;
      rs2 = $urandom;
      drive(7'h33, f3, 7'h01, rs1, rs2, 32'd0, 32'h0, 5'd11);
      step;
      id_ex_valid = 1'b0;
      step;
      step;
      chk1($sformatf("mul%0d_valid", k), ex_mem_valid, 1'b1);
      chk($sformatf("mul%0d_f3_%0d_result", k, f3), ex_mem_alu_result, mul_ref(f3, rs1, rs2));
    end
    // Reset while in MUL1 discards the multiply
    drive(7'h33, 3'd0, 7'h01, 32'd6, 32'd7, 32'd0, 32'h0, 5'd12);
    step;
    id_ex_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("mul_rst_valid", ex_mem_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step;
      chk1($sformatf("mul_rst_after%0d_valid", c), ex_mem_valid, 1'b0);
      chk1($sformatf("mul_rst_after%0d_ready", c), ex_ready, 1'b1);
    end
`endif

    // Randomized traffic against the reference model
    m_valid = 1'b0; m_rv = 1'b0; m_res = '0; m_rs2 = '0; m_pc4 = '0; m_rpc = '0;
    m_rd = '0; m_f3 = '0; m_op = '0; m_rw = 1'b0; m_ill = 1'b0;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 11))
        0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h37;  3: op = 7'h17;
        4: op = 7'h6f;  5: op = 7'h67;  6: op = 7'h03;  7: op = 7'h23;
        8: op = 7'h63;  9: op = 7'h0f;  10: op = 7'h73;
        default: begin tmp = $urandom; op = tmp[6:0]; end
      endcase
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: begin tmp = $urandom; f7 = tmp[6:0]; end
      endcase
`ifdef EX_STAGE_MUL_EN
      if (f7 == 7'h01) f7 = 7'h00;
`endif
      tmp = $urandom;
      f3  = tmp[2:0];
      rd  = tmp[7:3];
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(tmp[19:8]));
      tmp = $urandom;
      pc  = tmp & 32'hFFFF_FFFC;
      drive(op, f3, f7, rs1, rs2, imm, pc, rd);
      id_ex_valid  = ($urandom_range(0, 3) != 0);
      ex_mem_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk1($sformatf("rnd%0d_ex_ready", it), ex_ready, !m_valid || ex_mem_ready);
      xfer = id_ex_valid && (!m_valid || ex_mem_ready);
      if (xfer) begin
        e = model(op, f3, f7, rs1, rs2, imm, pc, rd);
        m_valid = 1'b1; m_res = e.res; m_rw = e.rw; m_ill = e.ill; m_rs2 = rs2;
        m_pc4 = pc + 32'd4; m_rd = rd; m_f3 = f3; m_op = op; m_rv = e.rv; m_rpc = e.rpc;
      end else begin
        if (ex_mem_ready) m_valid = 1'b0;
        m_rv = 1'b0;
      end
      step;
      chk1($sformatf("rnd%0d_valid", it), ex_mem_valid, m_valid);
      if (m_valid) begin
        chk($sformatf("rnd%0d_op%02h_result", it, m_op), ex_mem_alu_result, m_res);
        chk1($sformatf("rnd%0d_reg_write", it), ex_mem_reg_write, m_rw);
        chk1($sformatf("rnd%0d_illegal", it), ex_mem_illegal, m_ill);
        chk($sformatf("rnd%0d_rs2", it), ex_mem_rs2_data, m_rs2);
        chk($sformatf("rnd%0d_pc_4", it), ex_mem_pc_4, m_pc4);
        chk($sformatf("rnd%0d_fields", it), {17'd0, ex_mem_rd, ex_mem_funct3, ex_mem_opcode},
            {17'd0, m_rd, m_f3, m_op});
      end
      chk1($sformatf("rnd%0d_redirect", it), redirect_valid, m_rv);
      if (m_rv) chk($sformatf("rnd%0d_redirect_pc", it), redirect_pc, m_rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
